// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and the result.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, d, borrow_out, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, borrow_out, zero
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell processes operands LSB first.
// Define SERIAL_SUB_SAT_EN to clamp an underflowing result to zero (borrow_out still reports it).
module onebit_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             cell_d;
    logic             cell_bout;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] d_r;
    logic             borrow_r;
    logic             zero_r;

    onebit_sub u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // The newest difference bit enters at the MSB so the LSB-first result lands in place.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = cell_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            brw      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            d_r      <= '0;
            borrow_r <= 1'b0;
            zero_r   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        res_sr <= '0;
                        brw    <= 1'b0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    brw    <= cell_bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        borrow_r <= cell_bout;
`ifdef SERIAL_SUB_SAT_EN
                        if (cell_bout) begin
                            d_r    <= '0;
                            zero_r <= 1'b1;
                        end else begin
                            d_r    <= res_next;
                            zero_r <= (res_next == '0);
                        end
`else
                        d_r    <= res_next;
                        zero_r <= (res_next == '0);
`endif
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.d          = d_r;
    assign bus.borrow_out = borrow_r;
    assign bus.zero       = zero_r;
endmodule
